// File: rtl/pipe_adder_pkg.sv
// Shared elaboration-time helpers for the pipelined adder/subtractor.
package pipe_adder_pkg;

  function automatic int unsigned num_stages(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  function automatic bit chunk_ok(input int unsigned width, input int unsigned chunk);
    return (chunk != 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational CHUNK-bit add with carry in/out; cmsb is the carry into the top bit.
module adder_slice #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             cmsb
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
  // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c_in.
  assign cmsb    = a[CHUNK-1] ^ b[CHUNK-1] ^ s[CHUNK-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined carry-chained adder/subtractor: one CHUNK-bit slice per stage,
// operand skew and result deskew carried inside the pipeline registers.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid
);

  localparam int unsigned N = num_stages(WIDTH, CHUNK);

  if (!chunk_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("pipe_adder: WIDTH must be a nonzero multiple of CHUNK");
  end

  // Index k holds the state registered by stage k (0 = operand capture).
  logic [WIDTH-1:0] a_r  [0:N];
  logic [WIDTH-1:0] bx_r [0:N];
  logic [WIDTH-1:0] s_r  [0:N];
  logic             c_r  [0:N];
  logic [CHUNK-1:0] sum_w [0:N-1];
  logic             co_w  [0:N-1];
  logic             cm_w  [0:N-1];
  logic [N:0]       v_r;
  logic             ovf_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r[0]  <= '0;
      bx_r[0] <= '0;
      s_r[0]  <= '0;
      c_r[0]  <= 1'b0;
      v_r     <= '0;
    end else if (ce) begin
      a_r[0]  <= a;
      bx_r[0] <= sub ? ~b : b;
      s_r[0]  <= '0;
      c_r[0]  <= cin ^ sub;
      v_r     <= {v_r[N-1:0], in_valid};
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_stage
    adder_slice #(.CHUNK(CHUNK)) u_slice (
      .a    (a_r[g][g*CHUNK +: CHUNK]),
      .b    (bx_r[g][g*CHUNK +: CHUNK]),
      .ci   (c_r[g]),
      .s    (sum_w[g]),
      .co   (co_w[g]),
      .cmsb (cm_w[g])
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        a_r[g+1]  <= '0;
        bx_r[g+1] <= '0;
        s_r[g+1]  <= '0;
        c_r[g+1]  <= 1'b0;
      end else if (ce) begin
        a_r[g+1]  <= a_r[g];
        bx_r[g+1] <= bx_r[g];
        // Lower slices ride along; this stage overwrites only its own slice.
        s_r[g+1]                   <= s_r[g];
        s_r[g+1][g*CHUNK +: CHUNK] <= sum_w[g];
        c_r[g+1]  <= co_w[g];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (ce) begin
      ovf_r <= cm_w[N-1] ^ co_w[N-1];
    end
  end

  assign s         = s_r[N];
  assign cout      = c_r[N];
  assign ovf       = ovf_r;
  assign out_valid = v_r[N];

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench: four configurations share stimulus and are checked
// against an arithmetic reference with an enabled-cycle scoreboard.
module tb_pipe_adder;

  localparam int NDUT = 4;

  int unsigned wd [NDUT] = '{32, 32, 64, 12};
  int unsigned ns [NDUT] = '{4, 1, 4, 3};

  logic        clk = 1'b0;
  logic        rst, ce, in_valid, cin, sub;
  logic [63:0] a, b;

  logic [31:0] s0, s1;
  logic [63:0] s2;
  logic [11:0] s3;
  logic [3:0]  co, ov, vo;
  logic [63:0] ds [NDUT];

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid),
    .a(a[31:0]), .b(b[31:0]), .cin(cin), .sub(sub),
    .s(s0), .cout(co[0]), .ovf(ov[0]), .out_valid(vo[0])
  );

  pipe_adder #(.WIDTH(32), .CHUNK(32)) dut_n1 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid),
    .a(a[31:0]), .b(b[31:0]), .cin(cin), .sub(sub),
    .s(s1), .cout(co[1]), .ovf(ov[1]), .out_valid(vo[1])
  );

  pipe_adder #(.WIDTH(64), .CHUNK(16)) dut_w64 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .s(s2), .cout(co[2]), .ovf(ov[2]), .out_valid(vo[2])
  );

  pipe_adder #(.WIDTH(12), .CHUNK(4)) dut_w12 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid),
    .a(a[11:0]), .b(b[11:0]), .cin(cin), .sub(sub),
    .s(s3), .cout(co[3]), .ovf(ov[3]), .out_valid(vo[3])
  );

  assign ds[0] = {32'd0, s0};
  assign ds[1] = {32'd0, s1};
  assign ds[2] = s2;
  assign ds[3] = {52'd0, s3};

  typedef struct {
    int unsigned due;
    logic [63:0] s;
    logic        c;
    logic        v;
  } exp_t;

  exp_t        sb [NDUT][$];
  int unsigned en_cnt;
  int          compared, mismatched;
  bit          armed;
  bit          ev;
  exp_t        e;
  logic [65:0] r;

  // Returns {ovf, cout, sum} for a w-bit add/subtract.
  function automatic logic [65:0] ref_add(input int w, input logic [63:0] x, input logic [63:0] y,
                                          input logic ci, input logic sb_);
    logic [64:0] m, xa, bx, sum;
    m   = (65'd1 << w) - 65'd1;
    xa  = {1'b0, x} & m;
    bx  = (sb_ ? ~{1'b0, y} : {1'b0, y}) & m;
    sum = xa + bx + {64'd0, ci ^ sb_};
    return {(xa[w-1] == bx[w-1]) && (sum[w-1] != xa[w-1]), sum[w], sum[63:0] & m[63:0]};
  endfunction

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard bookkeeping: an entry is due once N more enabled edges follow its capture edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < NDUT; d++) sb[d].delete();
      armed = 1'b1;
    end else if (ce) begin
      for (int d = 0; d < NDUT; d++)
        if (sb[d].size() > 0 && sb[d][0].due == en_cnt) void'(sb[d].pop_front());
      en_cnt++;
      if (in_valid) begin
        for (int d = 0; d < NDUT; d++) begin
          r     = ref_add(int'(wd[d]), a, b, cin, sub);
          e.due = en_cnt + ns[d];
          e.s   = r[63:0];
          e.c   = r[64];
          e.v   = r[65];
          sb[d].push_back(e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int d = 0; d < NDUT; d++) begin
        ev = sb[d].size() > 0 && sb[d][0].due == en_cnt;
        chk($sformatf("out_valid[%0d]", d), {65'd0, vo[d]}, {65'd0, ev});
        if (ev) begin
          chk($sformatf("s[%0d]", d),    {2'd0, ds[d]}, {2'd0, sb[d][0].s});
          chk($sformatf("cout[%0d]", d), {65'd0, co[d]}, {65'd0, sb[d][0].c});
          chk($sformatf("ovf[%0d]", d),  {65'd0, ov[d]}, {65'd0, sb[d][0].v});
        end
      end
    end
  end

  task automatic step(input logic rr, input logic ee, input logic vv, input logic [63:0] x,
                      input logic [63:0] y, input logic ci, input logic sbt);
    rst = rr; ce = ee; in_valid = vv; a = x; b = y; cin = ci; sub = sbt;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [63:0] x, y;
    logic        ci, sbt;
    compared = 0; mismatched = 0; en_cnt = 0; armed = 1'b0;
    rst = 1'b1; ce = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    // Reset with ce low must still clear everything.
    step(1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 64'hFFFF, 64'h1, 1'b1, 1'b0);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("reset_s[%0d]", d),    {2'd0, ds[d]}, 66'd0);
      chk($sformatf("reset_cout[%0d]", d), {65'd0, co[d]}, 66'd0);
      chk($sformatf("reset_ovf[%0d]", d),  {65'd0, ov[d]}, 66'd0);
    end

    chk("ref_wrap",     ref_add(32, 64'hFFFFFFFF, 64'h1, 1'b0, 1'b0), 66'h1_0000000000000000);
    chk("ref_sub_neg",  ref_add(32, 64'h5, 64'h7, 1'b0, 1'b1),        66'h0_00000000FFFFFFFE);
    chk("ref_sub_ovf",  ref_add(32, 64'h80000000, 64'h1, 1'b0, 1'b1), 66'h3_000000007FFFFFFF);
    chk("ref_boundary", ref_add(32, 64'h00FFFFFF, 64'h1, 1'b0, 1'b0), 66'h0_0000000001000000);
    chk("ref_w12_ovf",  ref_add(12, 64'h7FF, 64'h1, 1'b0, 1'b0),      66'h2_0000000000000800);

    idle(2);
    step(1'b0, 1'b1, 1'b1, 64'hFFFFFFFF, 64'h1, 1'b0, 1'b0);
    idle(7);
    step(1'b0, 1'b1, 1'b1, 64'h5, 64'h7, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 64'h80000000, 64'h1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 64'h00FFFFFF, 64'h1, 1'b0, 1'b0);
    idle(8);

    // Back-to-back stream; every fifth op is a carry ripple across a slice boundary.
    for (int i = 0; i < 100; i++) begin
      x = {$urandom, $urandom}; y = {$urandom, $urandom};
      ci = 1'($urandom); sbt = 1'($urandom);
      if (i % 5 == 0) begin
        x = (64'd1 << (4 * $urandom_range(1, 15))) - 64'd1;
        y = 64'd1; ci = 1'b0; sbt = 1'b0;
      end
      step(1'b0, 1'b1, 1'b1, x, y, ci, sbt);
    end
    idle(6);

    // Random clock enable and sparse valid.
    for (int i = 0; i < 200; i++) begin
      x = {$urandom, $urandom}; y = {$urandom, $urandom};
      step(1'b0, 1'($urandom), ($urandom_range(0, 9) < 7), x, y, 1'($urandom), 1'($urandom));
    end
    idle(8);

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
    step(1'b1, 1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    idle(6);
    step(1'b0, 1'b1, 1'b1, 64'h00FFFFFF00FFFFFF, 64'h1, 1'b0, 1'b0);
    idle(8);

    for (int d = 0; d < NDUT; d++)
      chk($sformatf("drained[%0d]", d), {34'd0, 32'(sb[d].size())}, 66'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
